// File: rtl/led_trail_pwm_if.sv
// Connects the position counter to the LED trail renderer: the one-hot
// position pattern goes in, the LED drive and frame marker come out.
interface led_trail_pwm_if;
  logic [7:0] pos;
  logic [7:0] led;
  logic       frame_start;

  modport master (output pos, input led, frame_start);
  modport slave  (input pos, output led, frame_start);
endinterface

// File: rtl/led_trail_pwm.sv
// Comet-tail LED renderer: lit positions snap to full brightness, then fade stepwise under PWM.
// Optional build macro LED_TRAIL_GAMMA_EN selects a square-law brightness curve.
module led_trail_pwm #(
  parameter int PWM_BITS  = 4,
  parameter int DECAY_DIV = 16
) (
  input logic            clk,
  input logic            reset,
  led_trail_pwm_if.slave bus
);
  localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] level [8];
  logic [7:0]          led_p1;
  logic                frame_start_p1;
  logic                decay_tick;
  logic [7:0]          led_next;

  function automatic logic [PWM_BITS-1:0] eff_of(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return lvl;
`endif
  endfunction

  assign decay_tick = (div_cnt == DIV_LAST);

  // Full level bypasses the comparator so MAX is steady-on rather than MAX/2^N duty.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < 8; i++) begin
      led_next[i] = (level[i] == MAX) || (pwm_cnt < eff_of(level[i]));
    end
  end

  // p1: level/counter state and the registered LED drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt        <= '0;
      div_cnt        <= '0;
      led_p1         <= '0;
      frame_start_p1 <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        level[i] <= '0;
      end
    end else begin
      pwm_cnt        <= pwm_cnt + 1'b1;
      div_cnt        <= decay_tick ? '0 : div_cnt + 1'b1;
      led_p1         <= led_next;
      frame_start_p1 <= (pwm_cnt == '0);
      for (int i = 0; i < 8; i++) begin
        if (bus.pos[i]) begin
          level[i] <= MAX;
        end else if (decay_tick && (level[i] != '0)) begin
          level[i] <= level[i] - 1'b1;
        end
      end
    end
  end

  assign bus.led         = led_p1;
  assign bus.frame_start = frame_start_p1;
endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: directed scenarios plus random position traffic,
// compared every cycle against an edge-count based brightness model.
module tb_led_trail_pwm;
  localparam int PWM_BITS  = 4;
  localparam int DECAY_DIV = 16;
  localparam int P         = 1 << PWM_BITS;
  localparam int MAX       = P - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  led_trail_pwm_if bus ();

  led_trail_pwm #(.PWM_BITS(PWM_BITS), .DECAY_DIV(DECAY_DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n;
  int         lvl [8];
  logic [7:0] exp_led;
  logic       exp_fs;
  bit         chk_en = 0;

  function automatic int eff_model(input int l);
`ifdef LED_TRAIL_GAMMA_EN
    return (l * l) / P;
`else
    return l;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // n counts edges since reset release; all counters are phases of n.
  task automatic model_edge(input logic [7:0] p);
    int pw;
    bit tick;
    pw   = n % P;
    tick = ((n % DECAY_DIV) == DECAY_DIV - 1);
    for (int i = 0; i < 8; i++) begin
      exp_led[i] = (lvl[i] == MAX) || (pw < eff_model(lvl[i]));
      if (p[i]) lvl[i] = MAX;
      else if (tick && lvl[i] > 0) lvl[i] = lvl[i] - 1;
    end
    exp_fs = (pw == 0);
    n++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("led", int'(bus.led), int'(exp_led));
      check("frame_start", int'(bus.frame_start), int'(exp_fs));
    end
  end

  task automatic step(input logic [7:0] p);
    bus.pos = p;
    @(posedge clk);
    model_edge(p);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_led", int'(bus.led), 0);
    check("reset_fs", int'(bus.frame_start), 0);
    n = 0;
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    exp_led = '0;
    exp_fs  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b, late_on, bad;
    bus.pos = '0;
    #3;
    do_reset();
    chk_en = 1;

    // Single pulse on bits 0 and 3: latency, level-14 duty, level-8 duty, full decay.
    step(8'h09);
    check("first_fs", int'(bus.frame_start), 1);
    check("first_led", int'(bus.led), 0);
    step(8'h00);
    check("set_latency", int'(bus.led[0]), 1);
    cnt_a = 0; cnt_b = 0; late_on = 0; bad = 0;
    for (int e = 2; e <= 300; e++) begin
      step(8'h00);
      if (e <= 15 && bus.led[0] != 1'b1) bad++;
      if (e >= 16 && e <= 31) cnt_a += int'(bus.led[0]);
      if (e >= 112 && e <= 127) cnt_b += int'(bus.led[0]);
      if (e >= 240 && (bus.led[0] || bus.led[3])) late_on++;
    end
    check("full_until_tick", bad, 0);
`ifdef LED_TRAIL_GAMMA_EN
    check("duty_level14", cnt_a, 12);
    check("duty_level8", cnt_b, 4);
`else
    check("duty_level14", cnt_a, 14);
    check("duty_level8", cnt_b, 8);
`endif
    check("dark_after_decay", late_on, 0);

    // Mid-run reset with all LEDs on, then frame marker cadence.
    for (int e = 0; e < 20; e++) step(8'hFF);
    check("all_on", int'(bus.led), 8'hFF);
    do_reset();
    cnt_a = 0;
    step(8'h00);
    check("fs_after_release", int'(bus.frame_start), 1);
    cnt_a += int'(bus.frame_start);
    for (int e = 1; e < 48; e++) begin
      step(8'h00);
      cnt_a += int'(bus.frame_start);
    end
    check("fs_count_48", cnt_a, 3);

    // Hold two bits, then release and compare their fades.
    do_reset();
    bad = 0;
    for (int e = 0; e < 100; e++) begin
      step(8'h81);
      if (e >= 1 && bus.led != 8'h81) bad++;
    end
    check("hold_81", bad, 0);
    bad = 0;
    for (int e = 0; e < 300; e++) begin
      step(8'h00);
      if (bus.led[7] != bus.led[0]) bad++;
    end
    check("lockstep_fade", bad, 0);

    // Set on the same edge as a decay tick while level is 5.
    do_reset();
    step(8'h04);
    for (int e = 1; e < 175; e++) step(8'h00);
    step(8'h04);
    cnt_a = 0;
    for (int e = 176; e <= 191; e++) begin
      step(8'h00);
      cnt_a += int'(bus.led[2]);
    end
    check("set_beats_decay", cnt_a, 16);

    // Random traffic with occasional resets.
    for (int e = 0; e < 2000; e++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(8'($urandom & $urandom & $urandom));
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream display stage for the bouncing one-hot position counter: it takes the 8-bit position pattern and drives 8 LEDs with a fading "comet tail". Every lit position snaps its LED to full brightness. Unlit LEDs then decay stepwise to dark. Brightness is rendered by a free-running PWM comparator, and the block's outputs go directly to the board LED pins.

## Interface
- PWM_BITS, 4: brightness/PWM resolution in bits (legal 2..8); MAX = 2^PWM_BITS-1
- DECAY_DIV, 16: clock cycles between decay steps (legal >= 1)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- pos  input  8  position pattern from the position counter; any pattern legal, sampled every edge
- led  output  8  LED drive, registered, 1 = on
- frame_start  output  1  registered one-cycle pulse marking start of each PWM frame

## Operation
- pwm_cnt: PWM_BITS-bit counter, +1 every cycle, wraps MAX -> 0.
- div_cnt: counts 0..DECAY_DIV-1, wraps to 0. decay_tick = (div_cnt == DECAY_DIV-1). With DECAY_DIV=1, decay_tick is 1 every cycle.
- level[i], i=0..7, PWM_BITS wide, per edge, priority order:
  - pos[i]==1 -> level[i] = MAX (set wins over a simultaneous decay_tick).
  - else decay_tick && level[i]>0 -> level[i]-1.
  - else hold. Saturates at 0, never wraps.
- eff[i] = level[i] (see Configuration for gamma).
- led[i] <= (level[i]==MAX) || (pwm_cnt < eff[i]). MAX is forced fully on, 0 is fully off, otherwise duty = eff/2^PWM_BITS.
- frame_start <= (pwm_cnt == 0). It is coincident with the led values computed for pwm_cnt==0.
- pos held high keeps level at MAX indefinitely. Multiple bits high are independent.

## Timing
- Reset (async assert): pwm_cnt=0, div_cnt=0, all level=0, led=8'h00, frame_start=0, all immediately without waiting for a clock edge. Reset is usable mid-operation; release is synchronous to the next edge.
- First edge after reset release: frame_start=1 (pwm_cnt was 0), led=0.
- pos[i] high at edge k -> level[i]=MAX after edge k -> led[i]=1 after edge k+1 (latency 2 edges from pos sample to LED).
- Decay: once pos[i] drops, reaching level 0 from MAX takes exactly MAX decay ticks, i.e. between (MAX-1)*DECAY_DIV+1 and MAX*DECAY_DIV cycles depending on div_cnt phase.
- frame_start period = 2^PWM_BITS cycles, width 1 cycle, never stops except under reset.
- div_cnt and pwm_cnt are independent of pos; pos activity never resets them.

## Configuration
- LED_TRAIL_GAMMA_EN defined: eff[i] = (level[i]*level[i]) >> PWM_BITS, computed at 2*PWM_BITS width then truncated. This gives a square-law perceptual fade; the MAX full-on override still applies (with PWM_BITS=4, level 8 -> eff 4, level 14 -> eff 12).
- Not defined: eff[i] = level[i] (linear). No extra multiplier logic is present.

## Test plan
- Reset mid-run: with led=8'hFF, assert reset between edges -> led=8'h00 and frame_start=0 before the next edge. Release -> frame_start=1 at the first edge, then every 16 cycles (PWM_BITS=4).
- Set latency: pos=8'h01 for one cycle at edge k -> led[0]=1 from edge k+1 and stays constantly 1 until the first decay tick. After that, level 14 -> led[0] high for 14 of each 16 cycles, low while pwm_cnt in {14,15}.
- Full decay (linear build, DECAY_DIV=16): after a single pos pulse on bit 3, led[3] reaches permanent 0 within 225..240 cycles. led[3] is never high afterward, and the level does not wrap to 15.
- Hold and multi-bit: pos=8'h81 held 100 cycles -> led[7] and led[0] constantly 1, led[6:1]=0. Then pos=0 -> both decay in lockstep with identical led waveforms.
- Set/decay collision: drive pos[2]=1 exactly on a decay_tick edge while level[2]=5 -> level[2]=15 (set wins), led[2] constantly 1 next cycle.
- Gamma build (LED_TRAIL_GAMMA_EN, PWM_BITS=4): force level 8 via decay from MAX -> led high 4 of 16 cycles (linear build: 8 of 16). Level 1 -> eff 0, led constantly 0.
